// File: rtl/rgb_matrix_pwm_scan.sv
// Row-scanned RGB LED matrix driver with per-pixel PWM grey levels and a
// double-buffered frame store; the host writes the back buffer, swaps land at frame end.
//
// state  | meaning
// IDLE   | disabled, all LEDs off, counters cleared
// BLANK  | inter-row dead time, BLANK_CYCLES cycles, all off
// LOAD   | latch front-buffer row into the shadow, still off
// ACTIVE | row lit, PWM steps through LEVELS slices of STEP_CYCLES each
module rgb_matrix_pwm_scan #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int PWM_BITS     = 4,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int REFRESH_RATE = 60,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      wr_en_i,
  input  logic [$clog2(ROWS)-1:0]   wr_row_i,
  input  logic [$clog2(COLS)-1:0]   wr_col_i,
  input  logic [3*PWM_BITS-1:0]     wr_rgb_i,
  input  logic                      swap_req_i,
  output logic                      swap_ack_o,
  output logic                      frame_start_o,
  output logic [ROWS-1:0]           led_row_o,
  output logic [COLS-1:0]           led_col_r_o,
  output logic [COLS-1:0]           led_col_g_o,
  output logic [COLS-1:0]           led_col_b_o
);

  localparam int LEVELS      = (1 << PWM_BITS) - 1;
  localparam int ROW_TIME    = CLK_FREQ / (REFRESH_RATE * ROWS);
  localparam int STEP_CYCLES = (ROW_TIME / LEVELS > 1) ? ROW_TIME / LEVELS : 1;
  localparam int RAW         = $clog2(ROWS);
  localparam int SW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int BW          = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int PXW         = 3 * PWM_BITS;

  typedef logic [COLS-1:0][PXW-1:0] row_t;
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_LOAD, S_ACTIVE} state_t;

  state_t              state_q;
  logic [RAW-1:0]      row_cnt_q;
  logic [SW-1:0]       step_q;
  logic [BW-1:0]       blank_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic                front_q;
  logic                pend_q;
  logic                swap_ack_q;
  logic                frame_start_q;
  logic [ROWS-1:0]     led_row_q;
  logic [COLS-1:0]     col_r_q, col_g_q, col_b_q;
  row_t                shadow_q;
  row_t                fb_q [2][ROWS];

  // Active-low column drive for one row at a given PWM slice, packed {R,G,B}.
  function automatic logic [3*COLS-1:0] drive(input row_t px, input logic [PWM_BITS-1:0] p);
    logic [COLS-1:0] r, g, b;
    r = '1;
    g = '1;
    b = '1;
    for (int c = 0; c < COLS; c++) begin
      r[c] = !(px[c][PXW-1 -: PWM_BITS] > p);
      g[c] = !(px[c][2*PWM_BITS-1 -: PWM_BITS] > p);
      b[c] = !(px[c][PWM_BITS-1:0] > p);
    end
    return {r, g, b};
  endfunction

  // Writes always go to the back buffer; in the swap cycle that is the new front.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          fb_q[b][r] <= '0;
    end else if (wr_en_i && int'(wr_row_i) < ROWS && int'(wr_col_i) < COLS) begin
      fb_q[~front_q][wr_row_i][wr_col_i] <= wr_rgb_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      row_cnt_q     <= '0;
      step_q        <= '0;
      blank_q       <= '0;
      pwm_q         <= '0;
      front_q       <= 1'b0;
      pend_q        <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      led_row_q     <= '0;
      col_r_q       <= '1;
      col_g_q       <= '1;
      col_b_q       <= '1;
      shadow_q      <= '0;
    end else begin
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      if (swap_req_i) pend_q <= 1'b1;
      if (!enable_i) begin
        state_q   <= S_IDLE;
        row_cnt_q <= '0;
        step_q    <= '0;
        blank_q   <= '0;
        pwm_q     <= '0;
        led_row_q <= '0;
        col_r_q   <= '1;
        col_g_q   <= '1;
        col_b_q   <= '1;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_BLANK;
            blank_q <= BW'(BLANK_CYCLES - 1);
          end
          S_BLANK: begin
            if (blank_q == '0) begin
              state_q       <= S_LOAD;
              frame_start_q <= (row_cnt_q == '0);
            end else begin
              blank_q <= blank_q - 1'b1;
            end
          end
          S_LOAD: begin
            state_q   <= S_ACTIVE;
            shadow_q  <= fb_q[front_q][row_cnt_q];
            step_q    <= SW'(STEP_CYCLES - 1);
            pwm_q     <= '0;
            led_row_q <= ROWS'(1) << row_cnt_q;
            {col_r_q, col_g_q, col_b_q} <= drive(fb_q[front_q][row_cnt_q], '0);
          end
          S_ACTIVE: begin
            if (step_q != '0) begin
              step_q <= step_q - 1'b1;
            end else if (pwm_q != PWM_BITS'(LEVELS - 1)) begin
              step_q <= SW'(STEP_CYCLES - 1);
              pwm_q  <= pwm_q + 1'b1;
              {col_r_q, col_g_q, col_b_q} <= drive(shadow_q, pwm_q + 1'b1);
            end else begin
              state_q   <= S_BLANK;
              blank_q   <= BW'(BLANK_CYCLES - 1);
              pwm_q     <= '0;
              led_row_q <= '0;
              col_r_q   <= '1;
              col_g_q   <= '1;
              col_b_q   <= '1;
              if (row_cnt_q == RAW'(ROWS - 1)) begin
                row_cnt_q <= '0;
                // Frame boundary: the only point a swap may land, so a frame never mixes buffers.
                if (pend_q || swap_req_i) begin
                  front_q    <= ~front_q;
                  swap_ack_q <= 1'b1;
                  pend_q     <= 1'b0;
                end
              end else begin
                row_cnt_q <= row_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign swap_ack_o    = swap_ack_q;
  assign frame_start_o = frame_start_q;
  assign led_row_o     = led_row_q;
  assign led_col_r_o   = col_r_q;
  assign led_col_g_o   = col_g_q;
  assign led_col_b_o   = col_b_q;

endmodule

// File: tb/tb_rgb_matrix_pwm_scan.sv
// Scoreboard bench for rgb_matrix_pwm_scan: a frame-position reference model
// predicts every output cycle, a monitor pops and compares on the falling edge.
module tb_rgb_matrix_pwm_scan;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int PB     = 2;
  localparam int CLKF   = 2400;
  localparam int RR     = 100;
  localparam int BLANK  = 2;
  localparam int LEVELS = (1 << PB) - 1;
  localparam int STEP   = ((CLKF / (RR * ROWS)) / LEVELS > 1) ? (CLKF / (RR * ROWS)) / LEVELS : 1;
  localparam int RP     = BLANK + 1 + STEP * LEVELS;
  localparam int FRAME  = ROWS * RP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic       swap_req = 1'b0;
  logic [1:0] wr_row = '0;
  logic [1:0] wr_col = '0;
  logic [5:0] wr_rgb = '0;
  logic       ack, fs;
  logic [3:0] row_o, r_o, g_o, b_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] row;
    logic [3:0] r, g, b;
    logic       ack, fs;
  } exp_t;

  exp_t q[$];

  int m_t;
  int m_front;
  int m_pend;
  int mem [2][ROWS][COLS];

  rgb_matrix_pwm_scan #(
    .ROWS(ROWS), .COLS(COLS), .PWM_BITS(PB), .CLK_FREQ(CLKF),
    .REFRESH_RATE(RR), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .wr_en_i(wr_en),
    .wr_row_i(wr_row), .wr_col_i(wr_col), .wr_rgb_i(wr_rgb),
    .swap_req_i(swap_req), .swap_ack_o(ack), .frame_start_o(fs),
    .led_row_o(row_o), .led_col_r_o(r_o), .led_col_g_o(g_o), .led_col_b_o(b_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t off_exp();
    exp_t e;
    e.row = '0; e.r = '1; e.g = '1; e.b = '1; e.ack = 1'b0; e.fs = 1'b0;
    return e;
  endfunction

  // t = cycles since the scan left IDLE (-1 while idle); the frame layout is
  // BLANK cycles off, one LOAD cycle off, then LEVELS slices of STEP cycles lit.
  function automatic exp_t predict(input int t, input bit a);
    exp_t e;
    int pos, rw, w, pwm, px;
    e = off_exp();
    e.ack = a;
    if (t >= 0) begin
      pos = t % FRAME;
      rw  = pos / RP;
      w   = pos % RP;
      e.fs = (w == BLANK) && (rw == 0);
      if (w > BLANK) begin
        pwm = (w - BLANK - 1) / STEP;
        e.row = 4'(1 << rw);
        for (int c = 0; c < COLS; c++) begin
          px = mem[m_front][rw][c];
          if (((px >> (2 * PB)) & LEVELS) > pwm) e.r[c] = 1'b0;
          if (((px >> PB) & LEVELS) > pwm)       e.g[c] = 1'b0;
          if ((px & LEVELS) > pwm)               e.b[c] = 1'b0;
        end
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    bit sp, a;
    if (!rst_n) begin
      m_t = -1; m_front = 0; m_pend = 0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            mem[b][r][c] = 0;
      q.push_back(off_exp());
    end else begin
      sp = en && (m_t >= 0) && ((m_t % FRAME) == FRAME - 1);
      if (swap_req) m_pend = 1;
      if (wr_en) mem[1 - m_front][wr_row][wr_col] = int'(wr_rgb);
      a = 1'b0;
      if (sp && m_pend != 0) begin
        m_front = 1 - m_front; m_pend = 0; a = 1'b1;
      end
      m_t = en ? m_t + 1 : -1;
      q.push_back(predict(m_t, a));
    end
  end

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
      end else begin
        e = q.pop_front();
        if (!rst_n) e = off_exp();
        if (row_o !== e.row || r_o !== e.r || g_o !== e.g || b_o !== e.b ||
            ack !== e.ack || fs !== e.fs) begin
          miscompares++;
          $display("FAIL outputs at %0t: got row=%b r=%b g=%b b=%b ack=%b fs=%b, expected row=%b r=%b g=%b b=%b ack=%b fs=%b",
                   $time, row_o, r_o, g_o, b_o, ack, fs, e.row, e.r, e.g, e.b, e.ack, e.fs);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input int r, input int c, input int rgb);
    wr_en = 1'b1;
    wr_row = 2'(r);
    wr_col = 2'(c);
    wr_rgb = 6'(rgb);
    tick();
  endtask

  // Advance until the current cycle sits at (row, offset) within the frame.
  task automatic wait_pos(input int rw, input int w, input string name);
    int n;
    n = 0;
    while (!(m_t >= 0 && ((m_t % FRAME) / RP) == rw && (m_t % RP) == w)) begin
      tick();
      n++;
      if (n > 4 * FRAME) begin
        vectors++;
        miscompares++;
        $display("FAIL wait_%s: position row %0d offset %0d not reached, got t=%0d", name, rw, w, m_t);
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    run(20);

    write(0, 0, 6'b110000);
    write(0, 1, 6'b100000);
    write(0, 2, 6'b010000);
    write(0, 3, 6'b000000);
    swap_req = 1'b1;
    tick();
    en = 1'b1;
    run(2 * FRAME + 5);

    for (int i = 0; i < 8; i++) write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 63));
    wait_pos(1, 5, "row1");
    swap_req = 1'b1;
    tick();
    wait_pos(2, 4, "row2");
    swap_req = 1'b1;
    tick();
    run(2 * FRAME);

    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr_en = 1'b1;
        wr_row = 2'($urandom_range(0, 3));
        wr_col = 2'($urandom_range(0, 3));
        wr_rgb = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 19) == 0) swap_req = 1'b1;
      if (en && $urandom_range(0, 79) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      tick();
    end
    en = 1'b1;

    wait_pos(2, 5, "disable");
    en = 1'b0;
    run(4);
    en = 1'b1;
    run(FRAME + 10);

    wait_pos(3, 8, "collision");
    wr_en = 1'b1;
    wr_row = 2'd3;
    wr_col = 2'd3;
    wr_rgb = 6'b000011;
    swap_req = 1'b1;
    tick();
    run(FRAME + 10);

    wait_pos(1, 5, "reset");
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(FRAME + 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
